// File: rtl/snl_pkg.sv
// Shared types and board data for the snakes-and-ladders token mover.
package snl_pkg;

   localparam int unsigned BOARD_MAX_DEF = 100;
   localparam int unsigned POS_W         = 7;

   typedef enum logic [2:0] {
      StIdle,
      StStep,
      StJump,
      StNext,
      StWin
   } state_e;

   // Single lookup only: no destination is also a source, so chaining never applies.
   function automatic logic [POS_W-1:0] jump_table(input logic [POS_W-1:0] pos);
      logic [POS_W-1:0] dst;
      dst = pos;
      case (pos)
         7'd4:    dst = 7'd14;
         7'd9:    dst = 7'd31;
         7'd28:   dst = 7'd84;
         7'd40:   dst = 7'd59;
         7'd71:   dst = 7'd91;
         7'd17:   dst = 7'd7;
         7'd54:   dst = 7'd34;
         7'd62:   dst = 7'd19;
         7'd87:   dst = 7'd24;
         7'd99:   dst = 7'd78;
         default: dst = pos;
      endcase
      return dst;
   endfunction

endpackage

// File: rtl/snl_step_timer.sv
// Loadable down-counter that paces token movement; tick is high while the count is zero.
module snl_step_timer #(
   parameter int unsigned STEP_CYCLES = 25_000_000
) (
   input  logic clock,
   input  logic Clear_b,
   input  logic load,
   output logic tick
);

   localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CntW-1:0] LoadVal = CntW'(STEP_CYCLES - 1);

   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = LoadVal;
      end else if (count_q != '0) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clock or negedge Clear_b) begin
      if (!Clear_b) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = (count_q == '0);

endmodule

// File: rtl/snl_token_mover.sv
// Two-player token mover: accepts dice rolls, steps tokens, applies snakes/ladders, finds winner.
// Optional macro SNL_EXTRA_TURN_ON_SIX_EN: a non-winning accepted 6 keeps the turn.
module snl_token_mover
   import snl_pkg::*;
#(
   parameter int unsigned BOARD_MAX   = BOARD_MAX_DEF,
   parameter int unsigned STEP_CYCLES = 25_000_000
) (
   input  logic       clock,
   input  logic       Clear_b,
   input  logic       roll_valid,
   input  logic [2:0] roll_val,
   output logic       roll_ready,
   output logic       roll_err,
   output logic [6:0] pos_p0,
   output logic [6:0] pos_p1,
   output logic       turn,
   output logic       busy,
   output logic       overshoot,
   output logic       winner_valid,
   output logic       winner
);

   localparam logic [7:0]       BoardMax8 = 8'(BOARD_MAX);
   localparam logic [POS_W-1:0] BoardMaxP = POS_W'(BOARD_MAX);

   state_e           state_q, state_d;
   logic [POS_W-1:0] pos0_q, pos0_d, pos1_q, pos1_d;
   logic             turn_q, turn_d;
   logic [2:0]       rem_q, rem_d;
   logic             winner_q, winner_d;
   logic             err_q, err_d;
   logic             ovs_q, ovs_d;

   logic             timer_load, tick;
   logic [POS_W-1:0] cur_pos, new_pos;
   logic             pos_wr;
   logic [7:0]       sum;
   logic             roll_legal, accept_legal;
   logic             keep_turn;

   snl_step_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_step_timer (
      .clock  (clock),
      .Clear_b(Clear_b),
      .load   (timer_load),
      .tick   (tick)
   );

   assign cur_pos      = turn_q ? pos1_q : pos0_q;
   assign sum          = {1'b0, cur_pos} + {5'b0, roll_val};
   assign roll_legal   = (roll_val != 3'd0) && (roll_val != 3'd7);
   assign accept_legal = (state_q == StIdle) && roll_valid && roll_legal;

`ifdef SNL_EXTRA_TURN_ON_SIX_EN
   logic six_q, six_d;

   assign six_d = accept_legal ? (roll_val == 3'd6) : six_q;

   always_ff @(posedge clock or negedge Clear_b) begin
      if (!Clear_b) begin
         six_q <= 1'b0;
      end else begin
         six_q <= six_d;
      end
   end

   assign keep_turn = six_q;
`else
   assign keep_turn = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      pos0_d     = pos0_q;
      pos1_d     = pos1_q;
      turn_d     = turn_q;
      rem_d      = rem_q;
      winner_d   = winner_q;
      err_d      = 1'b0;
      ovs_d      = 1'b0;
      timer_load = 1'b0;
      new_pos    = cur_pos;
      pos_wr     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (roll_valid) begin
               if (!roll_legal) begin
                  err_d = 1'b1;
               end else begin
                  rem_d = roll_val;
                  if (sum > BoardMax8) begin
                     ovs_d   = 1'b1;
                     state_d = StNext;
                  end else begin
                     timer_load = 1'b1;
                     state_d    = StStep;
                  end
               end
            end
         end
         StStep: begin
            if (tick) begin
               new_pos    = cur_pos + 7'd1;
               pos_wr     = 1'b1;
               rem_d      = rem_q - 3'd1;
               timer_load = 1'b1;
               if (rem_q == 3'd1) begin
                  state_d = StJump;
               end
            end
         end
         StJump: begin
            new_pos = jump_table(cur_pos);
            pos_wr  = 1'b1;
            state_d = StNext;
         end
         StNext: begin
            if (cur_pos == BoardMaxP) begin
               winner_d = turn_q;
               state_d  = StWin;
            end else begin
               turn_d  = keep_turn ? turn_q : ~turn_q;
               state_d = StIdle;
            end
         end
         StWin: begin
            state_d = StWin;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Only the active player's token ever moves.
      if (pos_wr) begin
         if (turn_q) begin
            pos1_d = new_pos;
         end else begin
            pos0_d = new_pos;
         end
      end
   end

   always_ff @(posedge clock or negedge Clear_b) begin
      if (!Clear_b) begin
         state_q  <= StIdle;
         pos0_q   <= '0;
         pos1_q   <= '0;
         turn_q   <= 1'b0;
         rem_q    <= '0;
         winner_q <= 1'b0;
         err_q    <= 1'b0;
         ovs_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos0_q   <= pos0_d;
         pos1_q   <= pos1_d;
         turn_q   <= turn_d;
         rem_q    <= rem_d;
         winner_q <= winner_d;
         err_q    <= err_d;
         ovs_q    <= ovs_d;
      end
   end

   assign roll_ready   = (state_q == StIdle);
   assign busy         = (state_q != StIdle) && (state_q != StWin);
   assign winner_valid = (state_q == StWin);
   assign winner       = winner_q;
   assign roll_err     = err_q;
   assign overshoot    = ovs_q;
   assign pos_p0       = pos0_q;
   assign pos_p1       = pos1_q;
   assign turn         = turn_q;

endmodule

// File: tb/tb_snl_token_mover.sv
// Directed scoreboard bench for snl_token_mover with STEP_CYCLES = 2.
module tb_snl_token_mover;

   localparam int unsigned StepCycles = 2;
   localparam int          BoardMax   = 100;

   logic       clock = 1'b0;
   logic       Clear_b;
   logic       roll_valid;
   logic [2:0] roll_val;
   logic       roll_ready, roll_err, turn, busy, overshoot, winner_valid, winner;
   logic [6:0] pos_p0, pos_p1;

   always #5 clock = ~clock;

   snl_token_mover #(
      .BOARD_MAX  (BoardMax),
      .STEP_CYCLES(StepCycles)
   ) dut (
      .clock       (clock),
      .Clear_b     (Clear_b),
      .roll_valid  (roll_valid),
      .roll_val    (roll_val),
      .roll_ready  (roll_ready),
      .roll_err    (roll_err),
      .pos_p0      (pos_p0),
      .pos_p1      (pos_p1),
      .turn        (turn),
      .busy        (busy),
      .overshoot   (overshoot),
      .winner_valid(winner_valid),
      .winner      (winner)
   );

   typedef struct {
      int p0;
      int p1;
      int trn;
      int wv;
      int win;
      int ovs;
      int err;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   int   m_pos[2];
   int   m_turn;
   int   m_won;
   int   m_winner;

   int   jt_src[10] = '{4, 9, 28, 40, 71, 17, 54, 62, 87, 99};
   int   jt_dst[10] = '{14, 31, 84, 59, 91, 7, 34, 19, 24, 78};

   int   seq[24] = '{4, 1, 3, 0, 7, 5, 2, 5, 5, 4, 4, 5, 5, 2, 5, 5, 2, 1, 3, 4, 3, 1, 5, 2};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int jt(input int p);
      for (int i = 0; i < 10; i++) begin
         if (p == jt_src[i]) return jt_dst[i];
      end
      return p;
   endfunction

   task automatic model_reset();
      m_pos[0] = 0;
      m_pos[1] = 0;
      m_turn   = 0;
      m_won    = 0;
      m_winner = 0;
   endtask

   task automatic model_push(input int v);
      exp_t e;
      int   np;
      bit   keep;
      keep  = 1'b0;
`ifdef SNL_EXTRA_TURN_ON_SIX_EN
      keep  = (v == 6);
`endif
      e.ovs = 0;
      e.err = 0;
      if (v == 0 || v == 7) begin
         e.err = 1;
      end else if (m_pos[m_turn] + v > BoardMax) begin
         e.ovs = 1;
         if (!keep) m_turn = 1 - m_turn;
      end else begin
         np = jt(m_pos[m_turn] + v);
         m_pos[m_turn] = np;
         if (np == BoardMax) begin
            m_won    = 1;
            m_winner = m_turn;
         end else if (!keep) begin
            m_turn = 1 - m_turn;
         end
      end
      e.p0  = m_pos[0];
      e.p1  = m_pos[1];
      e.trn = m_turn;
      e.wv  = m_won;
      e.win = m_winner;
      sb.push_back(e);
   endtask

   task automatic drive(input int v);
      @(negedge clock);
      check("ready_before_roll", roll_ready, 1);
      roll_valid = 1'b1;
      roll_val   = 3'(v);
      @(negedge clock);
      roll_valid = 1'b0;
      roll_val   = 3'd0;
   endtask

   task automatic wait_done(output int ovs_seen, output int err_seen);
      int n;
      n        = 0;
      ovs_seen = 0;
      err_seen = 0;
      while (1) begin
         if (overshoot === 1'b1) ovs_seen++;
         if (roll_err === 1'b1) err_seen++;
         if (roll_ready === 1'b1 || winner_valid === 1'b1) break;
         if (n >= 200) begin
            checks++;
            errors++;
            $error("FAIL move_timeout: observed=still busy expected=done within 200 cycles");
            break;
         end
         @(negedge clock);
         n++;
      end
   endtask

   task automatic compare_pop(input int ovs_seen, input int err_seen);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard: observed=empty expected=entry");
         return;
      end
      e = sb.pop_front();
      check("pos_p0", pos_p0, e.p0);
      check("pos_p1", pos_p1, e.p1);
      check("turn", turn, e.trn);
      check("winner_valid", winner_valid, e.wv);
      check("winner", winner, e.win);
      check("overshoot_pulses", ovs_seen, e.ovs);
      check("roll_err_pulses", err_seen, e.err);
   endtask

   task automatic do_roll(input int v);
      int o, r;
      model_push(v);
      drive(v);
      wait_done(o, r);
      compare_pop(o, r);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pos_p0"}, pos_p0, 0);
      check({tag, "_pos_p1"}, pos_p1, 0);
      check({tag, "_turn"}, turn, 0);
      check({tag, "_roll_ready"}, roll_ready, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_roll_err"}, roll_err, 0);
      check({tag, "_overshoot"}, overshoot, 0);
      check({tag, "_winner_valid"}, winner_valid, 0);
      check({tag, "_winner"}, winner, 0);
   endtask

   initial begin
      Clear_b    = 1'b0;
      roll_valid = 1'b0;
      roll_val   = 3'd0;
      model_reset();
      #12;
      check_reset_outputs("reset");
      @(negedge clock);
      Clear_b = 1'b1;

      // Timed first roll: one square every StepCycles after acceptance.
      model_push(3);
      drive(3);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         check("step_pos_p0", pos_p0, k / 2);
         check("step_busy", busy, 1);
      end
      check("step_pos_p1", pos_p1, 0);
      @(negedge clock);
      check("turn_before_next", turn, 0);
      @(negedge clock);
      check("ready_after_move", roll_ready, 1);
      compare_pop(0, 0);

      foreach (seq[i]) begin
         do_roll(seq[i]);
      end

      check("win_pos_p0", pos_p0, 100);
      check("win_pos_p1", pos_p1, 97);
      check("win_roll_ready", roll_ready, 0);
      check("win_busy", busy, 0);

      // Rolls offered while in WIN must be ignored.
      roll_valid = 1'b1;
      roll_val   = 3'd3;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         check("win_hold_valid", winner_valid, 1);
         check("win_hold_pos_p0", pos_p0, 100);
         check("win_hold_ready", roll_ready, 0);
      end
      roll_valid = 1'b0;
      roll_val   = 3'd0;

      #2 Clear_b = 1'b0;
      #1 check_reset_outputs("clear_from_win");
      @(negedge clock);
      Clear_b = 1'b1;
      model_reset();

      // Abort a roll of 6 mid-step with an asynchronous clear.
      drive(6);
      repeat (3) @(negedge clock);
      check("pre_abort_pos_p0", pos_p0, 1);
      check("pre_abort_busy", busy, 1);
      #2 Clear_b = 1'b0;
      #1 check_reset_outputs("abort");
      @(negedge clock);
      Clear_b = 1'b1;

      do_roll(6);
      check("six_from_zero", pos_p0, 6);
      do_roll(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
